matrix_stream_io: RTL and testbench

Serial front-end for the combinational 3x3 6-bit matrix multiplier core. Accepts the 18 operand elements (A then B) one per beat on a valid/ready stream and assembles them into the packed 54-bit `mat_a`/`mat_b` buses that feed the core. After a fixed settle time it captures the core's packed 54-bit result. It then streams the 9 result elements back out on a second valid/ready stream. This lets a narrow serial host drive the wide parallel multiplier.

---
 rtl/matrix_stream_io_if.sv | 13 +
 rtl/matrix_stream_io.sv | 125 ++++++++++++
 tb/tb_matrix_stream_io.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_stream_io_if.sv
// Element stream: one W-bit element per valid/ready beat, with an end-of-frame marker.
// The input stream leaves last unused; the result stream raises it on the final element.
interface matrix_stream_io_if #(
    parameter int W = 6
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/matrix_stream_io.sv
// Serial front-end for a combinational 3x3 matrix multiplier: loads A then B one
// element per beat, waits CALC_LAT cycles for the core, then streams the 9 results out.
module matrix_stream_io #(
    parameter int W        = 6,
    parameter int CALC_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_stream_io_if.slave   i_in,
    matrix_stream_io_if.master  o_out,
    output logic [9*W-1:0]      o_mat_a,
    output logic [9*W-1:0]      o_mat_b,
    input  logic [9*W-1:0]      i_mat_res,
    output logic                o_busy
);
    typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, SEND} state_t;

    localparam logic [3:0] LAST_IDX = 4'd8;
    localparam logic [3:0] LAT_M1   = 4'(CALC_LAT - 1);

    state_t       r_state, w_state_nxt;
    logic [3:0]   r_idx, w_idx_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic         w_wr_a, w_wr_b, w_cap;
    logic [W-1:0] r_a   [9];
    logic [W-1:0] r_b   [9];
    logic [W-1:0] r_res [9];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD_A;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The input side is always ready in the LOAD states, so a beat is just valid.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_wr_a      = 1'b0;
        w_wr_b      = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            LOAD_A: begin
                if (i_in.valid) begin
                    w_wr_a = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = LOAD_B;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            LOAD_B: begin
                if (i_in.valid) begin
                    w_wr_b = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = WAIT;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == LAT_M1) begin
                    w_cap       = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (o_out.ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = LOAD_A;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: w_state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
            end
        end else begin
            if (w_wr_a) r_a[r_idx] <= i_in.data;
            if (w_wr_b) r_b[r_idx] <= i_in.data;
            if (w_cap) begin
                for (int k = 0; k < 9; k++) begin
                    r_res[k] <= i_mat_res[9*W-1-W*k -: W];
                end
            end
        end
    end

    // Element 0 ([0][0]) lives in the MSBs of each packed bus.
    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign o_mat_a[9*W-1-W*k -: W] = r_a[k];
        assign o_mat_b[9*W-1-W*k -: W] = r_b[k];
    end

    assign i_in.ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign o_out.valid = (r_state == SEND);
    assign o_out.last  = (r_state == SEND) && (r_idx == LAST_IDX);
    assign o_out.data  = (r_state == SEND) ? r_res[r_idx] : '0;
    assign o_busy      = !((r_state == LOAD_A) && (r_idx == 4'd0));

endmodule

// File: tb/tb_matrix_stream_io.sv
// Scoreboard bench for matrix_stream_io driving a behavioural 3x3 mod-64 multiplier core.
module tb_matrix_stream_io;
    localparam int W  = 6;
    localparam int CL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9*W-1:0] mat_a, mat_b, mat_res;
    logic          busy;

    matrix_stream_io_if #(.W(W)) in_if ();
    matrix_stream_io_if #(.W(W)) out_if ();

    matrix_stream_io #(.W(W), .CALC_LAT(CL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_in     (in_if),
        .o_out    (out_if),
        .o_mat_a  (mat_a),
        .o_mat_b  (mat_b),
        .i_mat_res(mat_res),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [9*W-1:0] mmul(input logic [9*W-1:0] a, input logic [9*W-1:0] b);
        logic [9*W-1:0] r;
        logic [W-1:0]   s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int k = 0; k < 3; k++)
                    s = s + W'(a[9*W-1-W*(3*i+k) -: W] * b[9*W-1-W*(3*k+j) -: W]);
                r[9*W-1-W*(3*i+j) -: W] = s;
            end
        end
        return r;
    endfunction

    assign mat_res = mmul(mat_a, mat_b);

    logic [W-1:0] ID   [9] = '{6'd1, 6'd0, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0, 6'd0, 6'd1};
    logic [W-1:0] SEQ  [9] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
    logic [W-1:0] ONES [9] = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1};
    logic [W-1:0] MAXV [9] = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63};
    logic [W-1:0] THREES [9] = '{6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3, 6'd3};

    int vectors = 0;
    int miscompares = 0;
    int beats_out = 0;
    logic [W:0] exp_q [$];
    logic [W:0] mon_e;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] v [9]);
        for (int k = 0; k < 9; k++) exp_q.push_back({(k == 8), v[k]});
    endtask

    function automatic logic [9*W-1:0] pack(input logic [W-1:0] v [9]);
        logic [9*W-1:0] r;
        for (int k = 0; k < 9; k++) r[9*W-1-W*k -: W] = v[k];
        return r;
    endfunction

    // Monitor: every accepted output beat is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_if.valid && out_if.ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_if.data), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 64'(out_if.data), 64'(mon_e[W-1:0]));
                check("out_last", 64'(out_if.last), 64'(mon_e[W]));
            end
            beats_out++;
        end
    end

    task automatic put(input logic [W-1:0] d);
        int n;
        n = 0;
        in_if.data  = d;
        in_if.valid = 1'b1;
        while (!in_if.ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("put_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        in_if.valid = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] a [9], input logic [W-1:0] b [9], input bit gaps);
        for (int k = 0; k < 18; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            put(k < 9 ? a[k] : b[k-9]);
        end
    endtask

    task automatic wait_frame_end(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_if.valid && out_if.ready && out_if.last) && n < 300);
        if (n >= 300) check({nm, "_end_timeout"}, 64'(n), 64'd0);
        @(posedge clk); #1;
        check({nm, "_valid_after_last"}, 64'(out_if.valid), 64'd0);
        check({nm, "_ready_after_last"}, 64'(in_if.ready), 64'd1);
    endtask

    initial begin
        int n;
        int base;
        in_if.data   = '0;
        in_if.valid  = 1'b0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_if.ready), 64'd1);
        check("rst_out_valid", 64'(out_if.valid), 64'd0);
        check("rst_out_last", 64'(out_if.last), 64'd0);
        check("rst_out_data", 64'(out_if.data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mat_a", 64'(mat_a), 64'd0);
        check("rst_mat_b", 64'(mat_b), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity x 1..9 with latency and handshake checks
        push_frame(SEQ);
        load(ID, SEQ, 1'b0);
        check("id_in_ready_after_t", 64'(in_if.ready), 64'd0);
        check("id_out_valid_after_t", 64'(out_if.valid), 64'd0);
        check("id_busy_wait", 64'(busy), 64'd1);
        check("id_mat_a", 64'(mat_a), 64'(pack(ID)));
        check("id_mat_b", 64'(mat_b), 64'(pack(SEQ)));
        n = 0;
        while (!out_if.valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("id_latency", 64'(n), 64'(CL));
        wait_frame_end("id");

        // All ones: each element 1+1+1
        push_frame(THREES);
        load(ONES, ONES, 1'b0);
        wait_frame_end("ones");

        // 63*63*3 = 11907, 11907 mod 64 = 3
        push_frame(THREES);
        load(MAXV, MAXV, 1'b0);
        wait_frame_end("ovf");

        // Backpressure at idx 0 and idx 4, random input gaps
        out_if.ready = 1'b0;
        push_frame(THREES);
        base = beats_out;
        load(ONES, ONES, 1'b1);
        n = 0;
        while (!out_if.valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            check("bp0_valid", 64'(out_if.valid), 64'd1);
            check("bp0_data", 64'(out_if.data), 64'd3);
            check("bp0_last", 64'(out_if.last), 64'd0);
            @(posedge clk); #1;
        end
        out_if.ready = 1'b1;
        n = 0;
        while (beats_out < base + 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        out_if.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp4_valid", 64'(out_if.valid), 64'd1);
            check("bp4_data", 64'(out_if.data), 64'd3);
            check("bp4_last", 64'(out_if.last), 64'd0);
            @(posedge clk); #1;
        end
        out_if.ready = 1'b1;
        wait_frame_end("bp");
        check("bp_beats", 64'(beats_out - base), 64'd9);

        // Reset after 11 beats of a frame
        for (int k = 0; k < 9; k++) put(ID[k]);
        put(SEQ[0]);
        put(SEQ[1]);
        check("mid_mat_a_loaded", 64'(mat_a), 64'(pack(ID)));
        #2 rst_n = 1'b0;
        #1;
        check("mid_mat_a_clr", 64'(mat_a), 64'd0);
        check("mid_mat_b_clr", 64'(mat_b), 64'd0);
        check("mid_res_clr", 64'(dut.r_res[0]), 64'd0);
        check("mid_in_ready", 64'(in_if.ready), 64'd1);
        check("mid_out_valid", 64'(out_if.valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push_frame(SEQ);
        load(ID, SEQ, 1'b0);
        wait_frame_end("post_rst");

        // Back-to-back frames with no idle cycles
        push_frame(SEQ);
        push_frame(THREES);
        load(ID, SEQ, 1'b0);
        load(ONES, ONES, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
